// File: rtl/bitplane_streamer_if.sv
// Matrix-in / bit-plane-out stream bundle for bitplane_streamer.
// master = upstream transpose + downstream array side, slave = the streamer itself.
interface bitplane_streamer_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned BITS  = 8
);
  localparam int unsigned IdxW = (BITS > 1) ? $clog2(BITS) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*BITS-1:0]   in_matrix;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_plane;
  logic [IdxW-1:0]         out_bit_idx;
  logic                    out_last;

  modport master (
    output in_valid, in_matrix, out_ready,
    input  in_ready, out_valid, out_plane, out_bit_idx, out_last
  );

  modport slave (
    input  in_valid, in_matrix, out_ready,
    output in_ready, out_valid, out_plane, out_bit_idx, out_last
  );
endinterface

// File: rtl/bitplane_streamer.sv
// Two-entry ping-pong matrix buffer streaming one LANES-bit plane per step, MSB plane first.
// Optional `SKEW_EN: per-lane delay chains give a diagonal wavefront, with zero-plane drain steps.
module bitplane_streamer #(
  parameter int unsigned LANES = 16,
  parameter int unsigned BITS  = 8
) (
  input logic                clk,
  input logic                rst,
  bitplane_streamer_if.slave stream_io
);
  localparam int unsigned IdxW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BITS - 1);

  logic [LANES*BITS-1:0] mat_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [IdxW-1:0]       plane_idx_q, plane_idx_d;

  logic                  accept;
  logic                  has_data;
  logic                  real_step;
  logic                  at_last;
  logic                  free;
  logic [LANES-1:0]      cur_row;

  always_comb begin
    has_data  = (count_q != 2'd0);
    at_last   = (plane_idx_q == LastIdx);
    stream_io.in_ready = (count_q != 2'd2) & ~rst;
    accept    = stream_io.in_valid & stream_io.in_ready;
    real_step = has_data & stream_io.out_ready;
    free      = real_step & at_last;
    cur_row   = has_data ? mat_q[rd_ptr_q][32'(plane_idx_q) * LANES +: LANES] : '0;

    wr_ptr_d    = accept ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = free ? ~rd_ptr_q : rd_ptr_q;
    plane_idx_d = plane_idx_q;
    if (real_step) begin
      plane_idx_d = at_last ? '0 : plane_idx_q + IdxW'(1);
    end

    // Accept and free together leave the occupancy unchanged.
    unique case ({accept, free})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      plane_idx_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      plane_idx_q <= plane_idx_d;
    end
  end

  // Payload needs no reset: it is only observed while the entry is occupied.
  always_ff @(posedge clk) begin
    if (accept) begin
      mat_q[wr_ptr_q] <= stream_io.in_matrix;
    end
  end

`ifdef SKEW_EN
  localparam int unsigned DrW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [DrW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             draining;
  logic             step;
  logic [LANES-1:0] skew_plane;

  always_comb begin
    draining = ~has_data & (drain_cnt_q != '0);
    step     = (has_data | draining) & stream_io.out_ready;
    drain_cnt_d = drain_cnt_q;
    if (real_step) begin
      drain_cnt_d = DrW'(LANES - 1);
    end else if (draining && stream_io.out_ready) begin
      drain_cnt_d = drain_cnt_q - DrW'(1);
    end

    stream_io.out_valid   = has_data | draining;
    stream_io.out_plane   = skew_plane;
    stream_io.out_bit_idx = draining ? '0 : LastIdx - plane_idx_q;
    stream_io.out_last    = has_data & at_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_q <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Lane i sees lane i of the plane issued i steps ago; cur_row is zero while draining.
  assign skew_plane[0] = cur_row[0];

  for (genvar i = 1; i < LANES; i++) begin : g_lane
    logic [i-1:0] sh_q;
    if (i == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) begin
          sh_q <= '0;
        end else if (step) begin
          sh_q <= cur_row[i];
        end
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (rst) begin
          sh_q <= '0;
        end else if (step) begin
          sh_q <= {sh_q[i-2:0], cur_row[i]};
        end
      end
    end
    assign skew_plane[i] = sh_q[i-1];
  end
`else
  always_comb begin
    stream_io.out_valid   = has_data;
    stream_io.out_plane   = cur_row;
    stream_io.out_bit_idx = LastIdx - plane_idx_q;
    stream_io.out_last    = has_data & at_last;
  end
`endif

endmodule

// File: tb/tb_bitplane_streamer.sv
// Self-checking bench for bitplane_streamer: scoreboard of expected planes filled on accept,
// compared on every valid output cycle; directed backpressure/full/reset cases plus random traffic.
module tb_bitplane_streamer;
  localparam int unsigned LANES = 16;
  localparam int unsigned BITS  = 8;

  typedef struct packed {
    logic [LANES-1:0] plane;
    logic [2:0]       idx;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   run_len = 0;
  int   max_run = 0;
  exp_t sb [$];

  bitplane_streamer_if #(.LANES(LANES), .BITS(BITS)) sif ();

  bitplane_streamer #(.LANES(LANES), .BITS(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .stream_io (sif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LANES*BITS-1:0] make_const(input logic [BITS-1:0] v);
    logic [LANES*BITS-1:0] m;
    for (int r = 0; r < BITS; r++)
      for (int i = 0; i < LANES; i++) m[r*LANES + i] = v[BITS-1-r];
    return m;
  endfunction

  function automatic logic [LANES*BITS-1:0] make_ramp();
    logic [LANES*BITS-1:0] m;
    logic [BITS-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      v = BITS'(i);
      for (int r = 0; r < BITS; r++) m[r*LANES + i] = v[BITS-1-r];
    end
    return m;
  endfunction

`ifdef SKEW_EN
  logic [LANES-1:0] hist [LANES];
  int drain = 0;
`endif

  // Output monitor and scoreboard; one process so push/pop never race.
  always @(negedge clk) begin
    logic             real_v;
    logic             exp_v;
    logic [LANES-1:0] head;
    logic [LANES-1:0] exp_plane;
    if (rst) begin
      sb.delete();
      run_len = 0;
`ifdef SKEW_EN
      drain = 0;
      for (int j = 0; j < LANES; j++) hist[j] = '0;
`endif
    end else begin
      real_v = (sb.size() != 0);
      head   = real_v ? sb[0].plane : '0;
`ifdef SKEW_EN
      exp_v = real_v || (drain != 0);
      exp_plane[0] = head[0];
      for (int i = 1; i < LANES; i++) exp_plane[i] = hist[i][i];
`else
      exp_v     = real_v;
      exp_plane = head;
`endif
      check("out_valid", 32'(sif.out_valid), 32'(exp_v));
      if (sif.out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        check("out_plane", 32'(sif.out_plane), 32'(exp_plane));
        check("out_bit_idx", 32'(sif.out_bit_idx), real_v ? 32'(sb[0].idx) : 32'd0);
        check("out_last", 32'(sif.out_last), real_v ? 32'(sb[0].last) : 32'd0);
        if (sif.out_ready) begin
`ifdef SKEW_EN
          for (int j = LANES - 1; j > 1; j--) hist[j] = hist[j-1];
          hist[1] = head;
          drain = real_v ? LANES - 1 : drain - 1;
`endif
          if (real_v) void'(sb.pop_front());
        end
      end else begin
        run_len = 0;
      end
      if (sif.in_valid && sif.in_ready) begin
        for (int r = 0; r < BITS; r++)
          sb.push_back('{plane: sif.in_matrix[r*LANES +: LANES], idx: 3'(BITS-1-r),
                         last: (r == BITS-1)});
      end
    end
  end

  // Called and returns at posedge+1; holds in_valid until the matrix is taken.
  task automatic send(input logic [LANES*BITS-1:0] m);
    int   t = 0;
    logic acc = 1'b0;
    sif.in_valid  = 1'b1;
    sif.in_matrix = m;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = sif.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || sif.out_valid) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("idle_timeout", 32'(t < 400), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_matrix = '0;
    sif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_in_ready", 32'(sif.in_ready), 32'd0);
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_out_plane", 32'(sif.out_plane), 32'd0);
    check("rst_bit_idx", 32'(sif.out_bit_idx), 32'd7);
    check("rst_out_last", 32'(sif.out_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(sif.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: single A5 matrix, first plane the cycle after accept
    send(make_const(8'hA5));
    @(negedge clk);
    check("t1_latency", 32'(sif.out_valid), 32'd1);
    check("t1_first", 32'(sif.out_plane), 32'hFFFF);
    @(posedge clk);
    #1;
    wait_idle();

    // 2: three back-to-back matrices stream without bubbles
    max_run = 0;
    send(make_const(8'h3C));
    send(make_ramp());
    @(negedge clk);
    check("t2_full", 32'(sif.in_ready), 32'd0);
    @(posedge clk);
    #1;
    send(make_const(8'hC3));
    wait_idle();
`ifdef SKEW_EN
    check("t2_run", 32'(max_run), 32'd39);
`else
    check("t2_run", 32'(max_run), 32'd24);
`endif

    // 3: backpressure mid-matrix, then fill and block
    send(make_const(8'h96));
    repeat (3) @(posedge clk);
    #1;
    sif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t3_freeze_idx", 32'(sif.out_bit_idx), 32'd4);
    @(posedge clk);
    #1;
    send(make_const(8'h5A));
    sif.in_valid  = 1'b1;
    sif.in_matrix = make_const(8'hF0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t3_blocked", 32'(sif.in_ready), 32'd0);
    check("t3_hold_idx", 32'(sif.out_bit_idx), 32'd4);
    @(posedge clk);
    #1;
    sif.out_ready = 1'b1;
    send(make_const(8'hF0));
    wait_idle();

    // 4: full buffer, last-plane step with in_valid pending
    sif.out_ready = 1'b0;
    send(make_const(8'h11));
    send(make_const(8'h22));
    sif.in_valid  = 1'b1;
    sif.in_matrix = make_const(8'h44);
    sif.out_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!sif.out_last && t < 20);
    check("t4_found_last", 32'(sif.out_last), 32'd1);
    check("t4_last_ready", 32'(sif.in_ready), 32'd0);
    @(negedge clk);
    check("t4_next_ready", 32'(sif.in_ready), 32'd1);
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    wait_idle();

    // 5: reset mid-matrix with one queued
    send(make_const(8'h77));
    send(make_const(8'h88));
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (sif.out_bit_idx != 3'd3 && t < 20);
    check("t5_at_plane4", 32'(sif.out_bit_idx), 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(sif.out_valid), 32'd0);
    check("t5_ready", 32'(sif.in_ready), 32'd1);
    check("t5_bit_idx", 32'(sif.out_bit_idx), 32'd7);
    @(posedge clk);
    #1;
    send(make_const(8'hE7));
    @(negedge clk);
    check("t5_fresh_idx", 32'(sif.out_bit_idx), 32'd7);
    @(posedge clk);
    #1;
    wait_idle();

`ifdef SKEW_EN
    // 6: ramp matrix through the skew chains, 8 real + 15 drain steps
    max_run = 0;
    send(make_ramp());
    wait_idle();
    check("t6_run", 32'(max_run), 32'd23);
`endif

    // Random matrices under random backpressure
    fork
      begin
        for (int k = 0; k < 6; k++) send({$urandom, $urandom, $urandom, $urandom});
      end
      begin
        for (int k = 0; k < 120; k++) begin
          @(posedge clk);
          #1;
          sif.out_ready = 1'($urandom_range(0, 1));
        end
        sif.out_ready = 1'b1;
      end
    join
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
